// File: rtl/spi_flash_responder.sv
// ----------------------------------------------------------------------------
// spi_flash_responder
//
// SPI (mode 0) responder that emulates a read-only serial flash. The SPI pins
// are oversampled by clk_i (at least 16x sclk) through 2-flop synchronizers.
// Supported commands: 0x03 READ (24-bit address, streaming, one byte of
// prefetch), 0x9F JEDEC ID, 0x05 STATUS. Any other command is ignored for the
// rest of the frame. Data bytes are fetched over a simple req/ack port.
//
// Ports
//   clk_i      system clock
//   rst_i      asynchronous active-high reset
//   sclk_i     SPI clock from the controller (mode 0)
//   cs_n_i     chip select, active-low
//   mosi_i     controller-to-responder data
//   miso_o     responder-to-controller data
//   miso_oe_o  miso output enable
//   rd_req_o   byte fetch request (level, held until rd_ack_i)
//   rd_addr_o  byte address of the fetch, stable while rd_req_o is high
//   rd_ack_i   fetch complete, rd_data_i valid in the same cycle
//   rd_data_i  fetched byte
//   busy_o     high while the synchronized cs_n is low
// ----------------------------------------------------------------------------
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sclk_i,
  input  logic        cs_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_oe_o,
  output logic        rd_req_o,
  output logic [23:0] rd_addr_o,
  input  logic        rd_ack_i,
  input  logic [7:0]  rd_data_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    READ   = 3'd3,
    ID     = 3'd4,
    STATUS = 3'd5,
    IGNORE = 3'd6
  } state_e;

  // Synchronizers and edge-detect history
  logic       sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic       cs_meta_q, cs_sync_q, cs_prev_q;
  logic       mosi_meta_q, mosi_sync_q;
  logic [2:0] sync_vld_q;

  logic sclk_rise_s, sclk_fall_s, cs_rise_s, cs_fall_s, ack_s;

  // Control / datapath state
  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;        // next address to fetch
  logic        req_q, req_d;
  logic [23:0] req_addr_q, req_addr_d;
  logic        want_q, want_d;        // a fetch is wanted but not yet issued
  logic        discard_q, discard_d;  // outstanding fetch result is to be dropped
  logic [7:0]  buf_q, buf_d;
  logic        buf_vld_q, buf_vld_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic [1:0]  id_idx_q, id_idx_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic        underrun_q, underrun_d;
  logic        busy_q, busy_d;
  logic [7:0]  tx_byte_s;

  // Two-flop synchronizers plus one history flop for edge detection.
  // sync_vld_q marks when the whole chain holds real pin samples, so that
  // the reset values of the chain can never look like a cs_n falling edge
  // (a frame already in progress at reset release is not joined).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b1;
      cs_sync_q   <= 1'b1;
      cs_prev_q   <= 1'b1;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      sync_vld_q  <= 3'b000;
    end else begin
      sclk_meta_q <= sclk_i;
      sclk_sync_q <= sclk_meta_q;
      sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= cs_n_i;
      cs_sync_q   <= cs_meta_q;
      cs_prev_q   <= cs_sync_q;
      mosi_meta_q <= mosi_i;
      mosi_sync_q <= mosi_meta_q;
      sync_vld_q  <= {sync_vld_q[1:0], 1'b1};
    end
  end

  assign sclk_rise_s = sync_vld_q[2] &  sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall_s = sync_vld_q[2] & ~sclk_sync_q &  sclk_prev_q;
  assign cs_rise_s   = sync_vld_q[2] &  cs_sync_q   & ~cs_prev_q;
  assign cs_fall_s   = sync_vld_q[2] & ~cs_sync_q   &  cs_prev_q;
  assign ack_s       = req_q & rd_ack_i;

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 5'd0;
      cmd_q      <= 8'h00;
      addr_q     <= 24'h000000;
      req_q      <= 1'b0;
      req_addr_q <= 24'h000000;
      want_q     <= 1'b0;
      discard_q  <= 1'b0;
      buf_q      <= 8'h00;
      buf_vld_q  <= 1'b0;
      tx_sr_q    <= 8'h00;
      tx_cnt_q   <= 3'd0;
      id_idx_q   <= 2'd0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      req_addr_q <= req_addr_d;
      want_q     <= want_d;
      discard_q  <= discard_d;
      buf_q      <= buf_d;
      buf_vld_q  <= buf_vld_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
      id_idx_q   <= id_idx_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic: fetch handshake, frame FSM and serial shifting.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    req_d      = req_q;
    req_addr_d = req_addr_q;
    want_d     = want_q;
    discard_d  = discard_q;
    buf_d      = buf_q;
    buf_vld_d  = buf_vld_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;
    id_idx_d   = id_idx_q;
    miso_d     = miso_q;
    oe_d       = oe_q;
    underrun_d = underrun_q;
    busy_d     = ~cs_sync_q;
    tx_byte_s  = 8'hFF;

    // Fetch completion: a result that arrived too late is dropped.
    if (ack_s) begin
      req_d     = 1'b0;
      discard_d = 1'b0;
      if (!discard_q) begin
        buf_d     = rd_data_i;
        buf_vld_d = 1'b1;
      end else begin
        buf_vld_d = buf_vld_q;
      end
    end else begin
      req_d = req_q;
    end

    // Issue a wanted fetch only once nothing is outstanding; the address
    // register then advances (24-bit wrap is natural overflow).
    if (want_q && !req_q) begin
      req_d      = 1'b1;
      req_addr_d = addr_q;
      addr_d     = addr_q + 24'd1;
      want_d     = 1'b0;
    end else begin
      want_d = want_q;
    end

    case (state_q)
      IDLE: begin
        if (cs_fall_s) begin
          state_d   = CMD;
          bit_cnt_d = 5'd0;
          tx_cnt_d  = 3'd0;
          id_idx_d  = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end

      CMD: begin
        if (sclk_rise_s) begin
          cmd_d = {cmd_q[6:0], mosi_sync_q};
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = 5'd0;
            case ({cmd_q[6:0], mosi_sync_q})
              8'h03:   state_d = ADDR;
              8'h9F:   state_d = ID;
              8'h05:   state_d = STATUS;
              default: state_d = IGNORE;
            endcase
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      ADDR: begin
        if (sclk_rise_s) begin
          addr_d = {addr_q[22:0], mosi_sync_q};
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = 5'd0;
            state_d   = READ;
            want_d    = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end

      READ, ID, STATUS: begin
        if (sclk_fall_s) begin
          tx_cnt_d = tx_cnt_q + 3'd1;
          if (tx_cnt_q == 3'd0) begin
            // Byte boundary: this edge drives the MSB of a new byte.
            oe_d = 1'b1;
            if (state_q == READ) begin
              if (buf_vld_q) begin
                tx_byte_s = buf_q;
              end else if (ack_s && !discard_q) begin
                tx_byte_s = rd_data_i;
              end else begin
                tx_byte_s  = 8'hFF;
                underrun_d = 1'b1;
              end
              buf_vld_d = 1'b0;
              // A still-outstanding fetch is now too late: drop its data and
              // let a replacement fetch follow. Otherwise prefetch the next
              // byte unless a fetch is already waiting to be issued.
              if (req_q && !rd_ack_i && !discard_q) begin
                discard_d = 1'b1;
                want_d    = 1'b1;
              end else if (!want_q) begin
                want_d = 1'b1;
              end else begin
                want_d = want_d;
              end
            end else if (state_q == ID) begin
              case (id_idx_q)
                2'd0:    tx_byte_s = JEDEC_ID[23:16];
                2'd1:    tx_byte_s = JEDEC_ID[15:8];
                2'd2:    tx_byte_s = JEDEC_ID[7:0];
                default: tx_byte_s = 8'hFF;
              endcase
              if (id_idx_q == 2'd3) begin
                id_idx_d = 2'd3;
              end else begin
                id_idx_d = id_idx_q + 2'd1;
              end
            end else begin
              tx_byte_s = STATUS_VAL;
            end
            miso_d  = tx_byte_s[7];
            tx_sr_d = {tx_byte_s[6:0], 1'b0};
          end else begin
            miso_d  = tx_sr_q[7];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
          end
        end else begin
          tx_cnt_d = tx_cnt_q;
        end
      end

      IGNORE: begin
        state_d = IGNORE;
        oe_d    = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // End of frame wins over everything. A fetch that stays outstanding is
    // left to complete on the bus, but its data is thrown away.
    if (cs_rise_s) begin
      state_d    = IDLE;
      miso_d     = 1'b0;
      oe_d       = 1'b0;
      buf_vld_d  = 1'b0;
      want_d     = 1'b0;
      underrun_d = 1'b0;
      discard_d  = req_d;
      tx_cnt_d   = 3'd0;
      bit_cnt_d  = 5'd0;
    end else begin
      state_d = state_d;
    end
  end

  assign miso_o    = miso_q;
  assign miso_oe_o = oe_q;
  assign rd_req_o  = req_q;
  assign rd_addr_o = req_addr_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed testbench for spi_flash_responder: an SPI mode-0 controller model
// driven from tasks, a byte memory returning addr[7:0] after a programmable
// latency, and hand-computed expected bytes/addresses.
module tb_spi_flash_responder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sclk_i;
  logic        cs_n_i;
  logic        mosi_i;
  logic        miso_o;
  logic        miso_oe_o;
  logic        rd_req_o;
  logic [23:0] rd_addr_o;
  logic        rd_ack_i;
  logic [7:0]  rd_data_i;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;
  int mem_lat  = 2;
  int wait_cnt = 0;
  int oe_hi_cnt = 0;
  int req_cnt  = 0;
  int stab_err = 0;
  logic        prev_req = 1'b0;
  logic [23:0] prev_addr = 24'h000000;
  logic [23:0] addr_log [$];
  logic [7:0]  rx_buf [16];

  always #5 clk_i = ~clk_i;

  spi_flash_responder dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sclk_i    (sclk_i),
    .cs_n_i    (cs_n_i),
    .mosi_i    (mosi_i),
    .miso_o    (miso_o),
    .miso_oe_o (miso_oe_o),
    .rd_req_o  (rd_req_o),
    .rd_addr_o (rd_addr_o),
    .rd_ack_i  (rd_ack_i),
    .rd_data_i (rd_data_i),
    .busy_o    (busy_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model and bus monitors, evaluated on the falling clk edge.
  initial begin
    rd_ack_i  = 1'b0;
    rd_data_i = 8'h00;
    forever begin
      @(negedge clk_i);
      if (rd_req_o && prev_req && (rd_addr_o != prev_addr)) stab_err++;
      if (rd_req_o && !prev_req) req_cnt++;
      if (miso_oe_o) oe_hi_cnt++;
      if (rd_ack_i) begin
        rd_ack_i = 1'b0;
        wait_cnt = 0;
      end else if (rd_req_o) begin
        if (wait_cnt >= mem_lat) begin
          rd_ack_i  = 1'b1;
          rd_data_i = rd_addr_o[7:0];
          addr_log.push_back(rd_addr_o);
        end else begin
          wait_cnt++;
        end
      end
      prev_req  = rd_req_o;
      prev_addr = rd_addr_o;
    end
  end

  // Shift nbits (MSB first) of tx; sample miso on each sclk rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi_i = tx[i];
      #80;
      sclk_i = 1'b1;
      rx[i]  = miso_o;
      #80;
      sclk_i = 1'b0;
    end
  endtask

  task automatic start_frame(input logic [7:0] cmd);
    logic [7:0] d;
    cs_n_i = 1'b0;
    #80;
    spi_bits(cmd, 8, d);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [7:0] d;
    spi_bits(a[23:16], 8, d);
    spi_bits(a[15:8], 8, d);
    spi_bits(a[7:0], 8, d);
  endtask

  task automatic read_bytes(input int n);
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      spi_bits(8'h00, 8, d);
      rx_buf[k] = d;
    end
  endtask

  task automatic end_frame();
    #80;
    cs_n_i = 1'b1;
    #160;
  endtask

  task automatic wait_req_low(input int max_cyc);
    int c = 0;
    while (rd_req_o && (c < max_cyc)) begin
      @(negedge clk_i);
      c++;
    end
    check_eq("req_drop_timeout", {31'd0, rd_req_o}, 32'd0);
  endtask

  initial begin
    rst_i  = 1'b1;
    sclk_i = 1'b0;
    cs_n_i = 1'b1;
    mosi_i = 1'b0;
    repeat (4) @(negedge clk_i);

    // Reset state
    check_eq("rst_miso", {31'd0, miso_o}, 32'd0);
    check_eq("rst_oe", {31'd0, miso_oe_o}, 32'd0);
    check_eq("rst_req", {31'd0, rd_req_o}, 32'd0);
    check_eq("rst_addr", {8'd0, rd_addr_o}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_i = 1'b0;
    #50;

    // Streaming read at 0x000100: data = addr[7:0]
    addr_log.delete();
    start_frame(8'h03);
    send_addr(24'h000100);
    check_eq("read_oe_before_data", {31'd0, miso_oe_o}, 32'd0);
    read_bytes(8);
    check_eq("read_busy", {31'd0, busy_o}, 32'd1);
    check_eq("read_oe", {31'd0, miso_oe_o}, 32'd1);
    end_frame();
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("read_byte%0d", k), {24'd0, rx_buf[k]}, k);
    end
    check_eq("read_nreq", {31'd0, (addr_log.size() >= 8)}, 32'd1);
    for (int k = 0; k < 8 && k < addr_log.size(); k++) begin
      check_eq($sformatf("read_addr%0d", k), {8'd0, addr_log[k]}, 32'h100 + k);
    end

    // Address wrap at 0xFFFFFE
    addr_log.delete();
    start_frame(8'h03);
    send_addr(24'hFFFFFE);
    read_bytes(4);
    end_frame();
    check_eq("wrap_byte0", {24'd0, rx_buf[0]}, 32'hFE);
    check_eq("wrap_byte1", {24'd0, rx_buf[1]}, 32'hFF);
    check_eq("wrap_byte2", {24'd0, rx_buf[2]}, 32'h00);
    check_eq("wrap_byte3", {24'd0, rx_buf[3]}, 32'h01);
    check_eq("wrap_nreq", {31'd0, (addr_log.size() >= 4)}, 32'd1);
    if (addr_log.size() >= 4) begin
      check_eq("wrap_addr0", {8'd0, addr_log[0]}, 32'hFFFFFE);
      check_eq("wrap_addr1", {8'd0, addr_log[1]}, 32'hFFFFFF);
      check_eq("wrap_addr2", {8'd0, addr_log[2]}, 32'h000000);
      check_eq("wrap_addr3", {8'd0, addr_log[3]}, 32'h000001);
    end

    // JEDEC ID
    start_frame(8'h9F);
    read_bytes(4);
    end_frame();
    check_eq("id_byte0", {24'd0, rx_buf[0]}, 32'hEF);
    check_eq("id_byte1", {24'd0, rx_buf[1]}, 32'h40);
    check_eq("id_byte2", {24'd0, rx_buf[2]}, 32'h16);
    check_eq("id_byte3", {24'd0, rx_buf[3]}, 32'hFF);

    // Unknown command is ignored
    #100;
    oe_hi_cnt = 0;
    req_cnt   = 0;
    start_frame(8'hAB);
    read_bytes(2);
    end_frame();
    check_eq("ignore_oe_cycles", oe_hi_cnt, 32'd0);
    check_eq("ignore_req_count", req_cnt, 32'd0);

    // cs_n rises after bit 3 of the second data byte
    start_frame(8'h03);
    send_addr(24'h0000FE);
    read_bytes(1);
    begin
      logic [7:0] d;
      spi_bits(8'h00, 5, d);
      check_eq("abort_bits", {24'd0, d}, 32'hF8);
    end
    #40;
    check_eq("abort_miso_before", {31'd0, miso_o}, 32'd1);
    cs_n_i = 1'b1;
    #30;
    check_eq("abort_byte0", {24'd0, rx_buf[0]}, 32'hFE);
    check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
    check_eq("abort_oe", {31'd0, miso_oe_o}, 32'd0);
    check_eq("abort_miso", {31'd0, miso_o}, 32'd0);
    #130;
    start_frame(8'h05);
    read_bytes(1);
    check_eq("status_oe", {31'd0, miso_oe_o}, 32'd1);
    end_frame();
    check_eq("status_byte", {24'd0, rx_buf[0]}, 32'h00);

    // Fetch stalled longer than 40 sclk periods -> 0xFF bytes, underrun
    mem_lat = 700;
    start_frame(8'h03);
    send_addr(24'h000200);
    read_bytes(3);
    check_eq("underrun_flag", {31'd0, dut.underrun_q}, 32'd1);
    end_frame();
    check_eq("stall_byte0", {24'd0, rx_buf[0]}, 32'hFF);
    check_eq("stall_byte1", {24'd0, rx_buf[1]}, 32'hFF);
    wait_req_low(1000);
    check_eq("underrun_cleared", {31'd0, dut.underrun_q}, 32'd0);
    mem_lat = 2;
    #100;
    start_frame(8'h03);
    send_addr(24'h000040);
    read_bytes(2);
    end_frame();
    check_eq("post_stall_byte0", {24'd0, rx_buf[0]}, 32'h40);
    check_eq("post_stall_byte1", {24'd0, rx_buf[1]}, 32'h41);

    // Reset mid-frame: no resumption until a fresh cs_n falling edge
    start_frame(8'h03);
    begin
      logic [7:0] d;
      spi_bits(8'h12, 8, d);
      rst_i = 1'b1;
      #30;
      check_eq("midrst_oe", {31'd0, miso_oe_o}, 32'd0);
      check_eq("midrst_req", {31'd0, rd_req_o}, 32'd0);
      check_eq("midrst_addr", {8'd0, rd_addr_o}, 32'd0);
      check_eq("midrst_busy", {31'd0, busy_o}, 32'd0);
      rst_i = 1'b0;
      #50;
      oe_hi_cnt = 0;
      req_cnt   = 0;
      spi_bits(8'h34, 8, d);
      spi_bits(8'h56, 8, d);
      read_bytes(2);
    end
    end_frame();
    check_eq("midrst_no_oe", oe_hi_cnt, 32'd0);
    check_eq("midrst_no_req", req_cnt, 32'd0);
    start_frame(8'h9F);
    read_bytes(1);
    end_frame();
    check_eq("midrst_id_byte0", {24'd0, rx_buf[0]}, 32'hEF);

    check_eq("addr_stable_while_req", stab_err, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
